// File: rtl/synth_pkg.sv
// Shared types and constants for the PWM audio output path.
// Holds the sequencer state enum and the sample width.
package synth_pkg;

    localparam int SAMPLE_W = 12;

    localparam logic [SAMPLE_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one-clk tick every PRESCALE clk cycles.
// Ports: clk, n_rst (async low), clear (restart count), tick.
module pwm_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] r_cnt;

    // Tick is left ungated by clear: the period-wrap load
    // both consumes a tick and clears the counter.
    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= 8'd0;
        end else if (clear || tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// 12-bit PWM audio output with IDLE/RUN/STOP sequencing.
// Ports: clk, n_rst, en, mixed_sample in; pwm, sample_req, busy out.
module pwm_audio_out
    import synth_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] mixed_sample,
    output logic                pwm,
    output logic                sample_req,
    output logic                busy
);

    state_t              r_state;
    state_t              w_next;
    logic [SAMPLE_W-1:0] r_count;
    logic [SAMPLE_W-1:0] r_duty;
    logic [SAMPLE_W-1:0] w_count_nxt;
    logic [SAMPLE_W-1:0] w_duty_nxt;
    logic                r_pwm;
    logic                r_sreq;
    logic                w_tick;
    logic                w_last;
    logic                w_load;
    logic                w_clear;
    logic                w_pwm_nxt;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_last = w_tick && (r_count == COUNT_MAX);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) w_next = RUN;
            end
            RUN: begin
                if (w_last) begin
                    w_next = en ? RUN : IDLE;
                end else if (!en) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        w_load  = ((r_state == IDLE) && en) ||
                  ((r_state == RUN) && w_last && en);
        w_clear = (r_state == IDLE) || w_load;
        busy    = (r_state != IDLE);

        if (w_load || (w_next == IDLE)) begin
            w_count_nxt = '0;
        end else if (w_tick) begin
            w_count_nxt = r_count + 12'd1;
        end else begin
            w_count_nxt = r_count;
        end

        w_duty_nxt = w_load ? mixed_sample : r_duty;

        // pwm is computed for the coming cycle so the flop
        // output equals (count < duty) in that same cycle.
        w_pwm_nxt = (w_next != IDLE) && (w_count_nxt < w_duty_nxt);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
            r_sreq  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_duty  <= w_duty_nxt;
            r_pwm   <= w_pwm_nxt;
            r_sreq  <= w_load;
        end
    end

    assign pwm        = r_pwm;
    assign sample_req = r_sreq;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench for pwm_audio_out (PRESCALE 1 and 4).
// Expected per-period high/length pushed by stimulus, checked by monitor.
module tb_pwm_audio_out;

    typedef struct {
        int id;
        int hi;
        int len;
    } per_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [11:0] ms0 = 12'd0;
    logic [11:0] ms1 = 12'd0;
    logic        pwm0, sr0, bz0;
    logic        pwm1, sr1, bz1;
    logic [1:0]  pwm_v, sr_v, bz_v;

    int   tests  = 0;
    int   failed = 0;
    per_t q[$];

    always #5 clk = ~clk;

    pwm_audio_out #(.PRESCALE(1)) u_dut0 (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en0),
        .mixed_sample (ms0),
        .pwm          (pwm0),
        .sample_req   (sr0),
        .busy         (bz0)
    );

    pwm_audio_out #(.PRESCALE(4)) u_dut1 (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en1),
        .mixed_sample (ms1),
        .pwm          (pwm1),
        .sample_req   (sr1),
        .busy         (bz1)
    );

    assign pwm_v = {pwm1, pwm0};
    assign sr_v  = {sr1, sr0};
    assign bz_v  = {bz1, bz0};

    // Monitor: a period opens at sample_req and closes at the next
    // sample_req or when busy falls; reset discards an open period.
    int hi_c[2];
    int len_c[2];
    bit inp[2];
    bit prev_sr[2];

    task automatic finalize(input int d);
        per_t e;
        tests++;
        if (q.size() == 0) begin
            failed++;
            $display("FAIL period dut%0d: unexpected period hi=%0d len=%0d",
                     d, hi_c[d], len_c[d]);
        end else begin
            e = q.pop_front();
            if (e.id != d || e.hi != hi_c[d] || e.len != len_c[d]) begin
                failed++;
                $display("FAIL period dut%0d: got hi=%0d len=%0d, want dut%0d hi=%0d len=%0d",
                         d, hi_c[d], len_c[d], e.id, e.hi, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!n_rst) begin
                inp[d] = 1'b0;
            end else begin
                if (sr_v[d]) begin
                    tests++;
                    if (prev_sr[d] || !bz_v[d]) begin
                        failed++;
                        $display("FAIL sreq_shape dut%0d: prev=%0b busy=%0b, want prev=0 busy=1",
                                 d, prev_sr[d], bz_v[d]);
                    end
                    if (inp[d]) finalize(d);
                    inp[d]   = 1'b1;
                    hi_c[d]  = 0;
                    len_c[d] = 0;
                end else if (inp[d] && !bz_v[d]) begin
                    finalize(d);
                    inp[d] = 1'b0;
                end
                if (inp[d] && bz_v[d]) begin
                    len_c[d]++;
                    if (pwm_v[d]) hi_c[d]++;
                end
            end
            prev_sr[d] = sr_v[d];
        end
    end

    task automatic push(input int d, input int hi, input int len);
        per_t e;
        e.id  = d;
        e.hi  = hi;
        e.len = len;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_sreq(input int d, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sr_v[d] && n < budget);
        if (!sr_v[d]) begin
            tests++;
            failed++;
            $display("FAIL wait_sreq dut%0d: none within %0d cycles", d, budget);
        end
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bz_v[d] && n < budget);
        if (bz_v[d]) begin
            tests++;
            failed++;
            $display("FAIL wait_idle dut%0d: busy after %0d cycles", d, budget);
        end
    endtask

    initial begin
        #23;
        chk("rst_pwm", int'(pwm0), 0);
        chk("rst_sreq", int'(sr0), 0);
        chk("rst_busy", int'(bz0), 0);
        chk("rst_busy4", int'(bz1), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(bz0), 0);
        chk("idle_pwm", int'(pwm0), 0);

        // 1024, 1024, 0, 4095, 2000 then en dropped at count 100
        ms0 = 12'd1024;
        en0 = 1'b1;
        push(0, 1024, 4096);
        wait_sreq(0, 10);
        push(0, 1024, 4096);
        wait_sreq(0, 5000);
        ms0 = 12'd0;
        push(0, 0, 4096);
        wait_sreq(0, 5000);
        ms0 = 12'd4095;
        push(0, 4095, 4096);
        wait_sreq(0, 5000);
        ms0 = 12'd2000;
        push(0, 2000, 4096);
        wait_sreq(0, 5000);
        repeat (100) @(negedge clk);
        en0 = 1'b0;
        ms0 = 12'd77;
        wait_idle(0, 5000);
        repeat (20) @(negedge clk);
        chk("stop_no_sreq_busy", int'(bz0), 0);

        // Sample toggling between loads is ignored
        ms0 = 12'd700;
        en0 = 1'b1;
        push(0, 700, 4096);
        wait_sreq(0, 10);
        repeat (4000) begin
            @(negedge clk);
            ms0 = 12'($urandom);
        end
        ms0 = 12'd300;
        push(0, 300, 4096);
        wait_sreq(0, 200);
        repeat (2000) begin
            @(negedge clk);
            ms0 = 12'($urandom);
        end
        en0 = 1'b0;
        wait_idle(0, 5000);

        // Reset mid-period at count 500
        ms0 = 12'd900;
        en0 = 1'b1;
        wait_sreq(0, 10);
        repeat (500) @(negedge clk);
        chk("pre_rst_pwm", int'(pwm0), 1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(pwm0), 0);
        chk("mid_rst_busy", int'(bz0), 0);
        chk("mid_rst_sreq", int'(sr0), 0);
        repeat (2) @(negedge clk);
        ms0 = 12'd1500;
        push(0, 1500, 4096);
        n_rst = 1'b1;
        wait_sreq(0, 10);
        en0 = 1'b0;
        wait_idle(0, 5000);

        // PRESCALE = 4, duty 3
        ms1 = 12'd3;
        en1 = 1'b1;
        push(1, 12, 16384);
        wait_sreq(1, 10);
        repeat (10) @(negedge clk);
        en1 = 1'b0;
        wait_idle(1, 20000);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("end_busy0", int'(bz0), 0);
        chk("end_busy1", int'(bz1), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 Parameter PRESCALE, default 1, the number of clk cycles per PWM tick (legal range 1..255).
REQ-002 Port clk, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-003 Port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port en, input, 1 bit: playback enable.
REQ-005 Port mixed_sample, input, 12 bits: unsigned mixer output (0..4095), sampled only at load events.
REQ-006 Port pwm, output, 1 bit: PWM audio bit to the speaker filter; driven directly by a flip-flop.
REQ-007 Port sample_req, output, 1 bit: one-clk pulse marking that mixed_sample was captured.
REQ-008 Port busy, output, 1 bit: high while the state is RUN or STOP.

Function
REQ-009 States: IDLE, RUN, STOP.
REQ-010 IDLE: pwm=0, the count is held at 0, and the prescaler is held at 0.
REQ-011 IDLE -> RUN when en=1; that edge is a load event.
REQ-012 At a load event: duty_reg <= mixed_sample, count <= 0, prescaler <= 0, and sample_req is 1 for exactly the next clk cycle.
REQ-013 Tick: asserted for one clk every PRESCALE clk cycles while in RUN or STOP; the first tick occurs PRESCALE cycles after the load event.
REQ-014 count is 12 bits, unsigned, and increments by 1 on each tick.
REQ-015 RUN with count=4095 on a tick and en=1: the count wraps to 0 and this is a load event; the period is exactly 4096*PRESCALE clk cycles, with no gap cycle.
REQ-016 RUN with en=0 at any point: go to STOP, which finishes the current period using the unchanged duty_reg.
REQ-017 STOP with count=4095 on a tick: go to IDLE with no load event; en is ignored while in STOP.
REQ-018 pwm=1 in exactly those clk cycles, within RUN or STOP, where count < duty_reg.
REQ-019 The high time per period is duty_reg*PRESCALE clk cycles, starting the cycle after the load event.
REQ-020 duty_reg=0: pwm stays 0 for the whole period.
REQ-021 duty_reg=4095: pwm is low for exactly 1 tick per period; 100% duty is unreachable by design.
REQ-022 Changes on mixed_sample between load events are ignored; duty_reg is constant within a period.
REQ-023 A new load event shall never occur mid-period; en re-asserted during STOP has no effect until IDLE is reached.
REQ-024 sample_req shall never be asserted in IDLE or STOP, and never for two consecutive cycles.

Reset
REQ-025 While n_rst=0, state=IDLE, count=0, prescaler=0, duty_reg=0, pwm=0, sample_req=0, busy=0, applied asynchronously.
REQ-026 Reset asserted mid-period aborts the period immediately; after release with en=1, the first edge is a load event.

Structure
REQ-027 Shared package synth_pkg holds the state enum type (IDLE/RUN/STOP) and the constant SAMPLE_W=12.
REQ-028 The prescaler is a separate sub-module, pwm_prescaler (clk, n_rst, clear, tick), instantiated once.
REQ-029 count, duty_reg, state and pwm are registered in pwm_audio_out; no combinational path runs from mixed_sample to pwm.

Verification
REQ-030 Reset, then en=1 and mixed_sample=1024 with PRESCALE=1 -> sample_req pulse; pwm high for 1024 cycles, low for 3072; sample_req repeats every 4096 cycles.
REQ-031 mixed_sample=0, then 4095, on consecutive periods -> pwm 0 for 4096 cycles, then high 4095 and low 1.
REQ-032 en dropped at count=100 with mixed_sample=2000 -> pwm completes 2000 high / 2096 low, busy falls after count=4095, and there is no further sample_req.
REQ-033 PRESCALE=4, mixed_sample=3 -> pwm high 12 clk cycles per 16384-cycle period.
REQ-034 n_rst pulsed low at count=500 -> pwm, sample_req and busy are 0 immediately; re-start with en=1 gives a fresh load and the count restarts at 0.
REQ-035 mixed_sample toggled every cycle mid-period -> pwm width equals the value captured at the last sample_req.
